cdc_req_sender: RTL and testbench
=================================

Name: cdc_req_sender

Overview:
Source-side end of a 4-phase req/ack clock-domain-crossing handshake. Runs entirely in the sending clock domain. Captures a data word and drives a registered, glitch-free req level plus a stable data bus toward an unrelated receive domain. The receiver's ack arrives asynchronously; this block synchronises it internally before use. It pairs with the existing receive-side synchroniser to form a complete multi-bit CDC path.

Parameters:
WIDTH, 8, data word width
SYNC_STAGES, 2, flops in the ack synchroniser chain (minimum 2)
TIMEOUT_CYCLES, 1024, clk cycles allowed per handshake phase before timeout_err is flagged; 0 disables the timeout
CNT_WIDTH, 16, width of the completed-transfer counter

Ports:
clk  input  1  sending-domain clock, rising edge
rst  input  1  asynchronous, active-high reset
send_valid  input  1  upstream has a word to send
send_data  input  WIDTH  word to send
send_ready  output  1  block is idle and accepts a word this cycle
req  output  1  registered request level toward the receive domain
data_out  output  WIDTH  held data toward the receive domain; stable whenever req=1
ack_async  input  1  acknowledge from the receive domain, asynchronous to clk
done  output  1  one-cycle pulse when a full 4-phase handshake completes
busy  output  1  handshake in progress (state != IDLE)
timeout_err  output  1  sticky flag: a phase exceeded TIMEOUT_CYCLES
clr_err  input  1  synchronous clear for timeout_err
xfer_count  output  CNT_WIDTH  number of completed handshakes, wraps modulo 2^CNT_WIDTH

Behaviour:
- Reset (async assert; release synchronised by the user): state=IDLE, req=0, data_out=0, done=0, timeout_err=0, xfer_count=0, timeout counter=0, every sync flop=0. Consequently send_ready=1 and busy=0.
- ack_sync = output of the SYNC_STAGES-flop chain on ack_async. The FSM never samples ack_async directly.
- send_ready = (state==IDLE), combinational from state. busy = !send_ready.
- FSM:
  - IDLE: if send_valid at edge N, then data_out<=send_data, req<=1, state->REQ. req is high from cycle N+1.
  - REQ: hold req=1 and data_out. On the first edge with ack_sync=1: req<=0, state->RELEASE.
  - RELEASE: hold req=0 and data_out. On the first edge with ack_sync=0: state->IDLE, done<=1 for one cycle, xfer_count<=xfer_count+1.
- data_out changes only on acceptance in IDLE. It never changes while req=1 or in RELEASE.
- send_data is ignored outside IDLE. send_valid held through a busy period is accepted on the first IDLE cycle; the word captured is the one presented on that cycle.
- Back-to-back transfers: done and send_ready are both asserted in the same cycle, so a new word can be accepted that cycle. Minimum handshake period is 2·SYNC_STAGES + 2 cycles.
- Timeout:
  - The phase counter resets on every state change and increments in REQ and RELEASE.
  - When it reaches TIMEOUT_CYCLES, timeout_err<=1 and the counter saturates. The FSM keeps waiting; the handshake is never abandoned.
  - If clr_err and a new timeout occur in the same cycle, set wins.
- ack_sync already 1 on entering REQ (stale ack): REQ still waits for ack_sync=1, so it leaves REQ on the next edge. This is a protocol violation by the receiver; it is not detected.
- Reset mid-handshake: req drops immediately (async) and the FSM returns to IDLE. The receiver must tolerate an aborted req.
- xfer_count wraps from all-ones to 0 without any flag.

Decomposition:
- Shared package cdc_pkg holds the state enum/localparams (IDLE=2'd0, REQ=2'd1, RELEASE=2'd2) and the SYNC_STAGES minimum constant. The receive-side handshake block reuses the same package.
- Sub-module sync_ff (parameter STAGES, async active-high rst, 1-bit d/q) implements the ack synchroniser. It is also reusable by the receive side for req.

Test Plan:
- Reset: hold rst=1 for 50 ns with ack_async=0 -> req=0, data_out=0, send_ready=1, done=0, xfer_count=0, timeout_err=0.
- Single transfer: send_valid=1 and send_data=8'hA5 for one cycle; bench raises ack 3 cycles after req rises and lowers it 3 cycles after req falls.
  - Required: req rises at N+1; data_out=8'hA5 throughout; req falls SYNC_STAGES+1 edges after ack rises; done pulses once; xfer_count=1.
- Backpressure: send_data=8'h11 then 8'h22 with send_valid held high.
  - Required: 8'h11 is sent; send_ready=0 during the handshake; 8'h22 is captured in the cycle done pulses; data_out never changes while req=1.
- Timeout: TIMEOUT_CYCLES=8 and ack_async held at 0 after a request.
  - Required: timeout_err=1 after 8 cycles in REQ and req stays 1.
  - Required: a later ack completes normally and timeout_err stays 1 until clr_err=1.
- Mid-handshake reset: assert rst while in RELEASE -> req=0, busy=0, xfer_count=0 asynchronously; a later transfer completes normally.
- Counter wrap: CNT_WIDTH=2 with 5 transfers -> xfer_count sequence 1,2,3,0,1.

Source files
------------

// File: rtl/cdc_pkg.sv
// Shared definitions for the req/ack CDC handshake pair (sender and receiver sides).
// Holds the handshake state encoding, the synchroniser depth floor and sizing helpers.
package cdc_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    RELEASE = 2'd2
  } hs_state_e;

  localparam int SYNC_MIN_STAGES = 2;

  // A synchroniser shallower than two flops gives no real metastability protection.
  function automatic int clamp_stages(input int n);
    return (n < SYNC_MIN_STAGES) ? SYNC_MIN_STAGES : n;
  endfunction

  // Bits needed to hold 0..max_val; never less than one.
  function automatic int cnt_bits(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/cdc_req_sender_if.sv
// Upstream send handshake plus the req/ack/data crossing toward the receive domain.
interface cdc_req_sender_if #(
  parameter int WIDTH = 8
);

  logic             send_valid;
  logic [WIDTH-1:0] send_data;
  logic             send_ready;
  logic             req;
  logic [WIDTH-1:0] data_out;
  logic             ack_async;

  // slave: the sender block; master: upstream producer together with the receive side
  modport slave (
    input  send_valid,
    input  send_data,
    input  ack_async,
    output send_ready,
    output req,
    output data_out
  );

  modport master (
    output send_valid,
    output send_data,
    output ack_async,
    input  send_ready,
    input  req,
    input  data_out
  );

endinterface

// File: rtl/sync_ff.sv
// Multi-flop level synchroniser for a single asynchronous bit.
module sync_ff
  import cdc_pkg::*;
#(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  localparam int N = clamp_stages(STAGES);

  logic [N-1:0] chain;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chain <= '0;
    end else begin
      chain <= {chain[N-2:0], d};
    end
  end

  assign q = chain[N-1];

endmodule

// File: rtl/cdc_req_sender.sv
// Source side of a 4-phase req/ack CDC handshake: captures a word, drives req/data
// toward the receive domain and waits on the synchronised ack.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | no transfer; send_ready=1, next send_valid is accepted
// REQ     | req=1 with data held, waiting for ack_sync to rise
// RELEASE | req=0 with data held, waiting for ack_sync to fall
module cdc_req_sender
  import cdc_pkg::*;
#(
  parameter int WIDTH          = 8,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  cdc_req_sender_if.slave      bus,
  output logic                 done,
  output logic                 busy,
  output logic                 timeout_err,
  input  logic                 clr_err,
  output logic [CNT_WIDTH-1:0] xfer_count
);

  localparam int              TW      = cnt_bits(TIMEOUT_CYCLES);
  localparam bit              TO_EN   = (TIMEOUT_CYCLES > 0);
  localparam logic [TW-1:0]   TO_MAX  = TW'(TIMEOUT_CYCLES);
  localparam logic [TW-1:0]   TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  hs_state_e            state_q, state_d;
  logic                 req_q, req_d;
  logic [WIDTH-1:0]     data_q, data_d;
  logic                 done_q, done_d;
  logic [CNT_WIDTH-1:0] xfer_q, xfer_d;
  logic [TW-1:0]        phase_cnt_q, phase_cnt_d;
  logic                 to_set;
  logic                 err_q;
  logic                 ack_sync;

  sync_ff #(
    .STAGES (SYNC_STAGES)
  ) u_ack_sync (
    .clk (clk),
    .rst (rst),
    .d   (bus.ack_async),
    .q   (ack_sync)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      data_q  <= '0;
      done_q  <= 1'b0;
      xfer_q  <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      data_q  <= data_d;
      done_q  <= done_d;
      xfer_q  <= xfer_d;
    end
  end

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    data_d  = data_q;
    done_d  = 1'b0;
    xfer_d  = xfer_q;
    case (state_q)
      IDLE: begin
        if (bus.send_valid) begin
          data_d  = bus.send_data;
          req_d   = 1'b1;
          state_d = REQ;
        end
      end
      REQ: begin
        if (ack_sync) begin
          req_d   = 1'b0;
          state_d = RELEASE;
        end
      end
      RELEASE: begin
        if (!ack_sync) begin
          done_d  = 1'b1;
          xfer_d  = xfer_q + 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        req_d   = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // Phase timer: restarts on every state change and saturates at the limit, so the
  // error is raised once per stuck phase and can be cleared while still waiting.
  always_comb begin
    phase_cnt_d = phase_cnt_q;
    to_set      = 1'b0;
    if (state_d != state_q) begin
      phase_cnt_d = '0;
    end else if (TO_EN && (state_q != IDLE) && (phase_cnt_q != TO_MAX)) begin
      phase_cnt_d = phase_cnt_q + 1'b1;
      to_set      = (phase_cnt_q == TO_LAST);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_cnt_q <= '0;
      err_q       <= 1'b0;
    end else begin
      phase_cnt_q <= phase_cnt_d;
      if (to_set) begin
        err_q <= 1'b1;
      end else if (clr_err) begin
        err_q <= 1'b0;
      end
    end
  end

  assign bus.send_ready = (state_q == IDLE);
  assign bus.req        = req_q;
  assign bus.data_out   = data_q;
  assign busy           = (state_q != IDLE);
  assign done           = done_q;
  assign xfer_count     = xfer_q;
  assign timeout_err    = err_q;

endmodule

// File: tb/tb_cdc_req_sender.sv
// Self-checking bench for cdc_req_sender: scoreboard of sent words, an auto-ack
// receive-side model and directed reset/backpressure/timeout/wrap scenarios.
module tb_cdc_req_sender;

  localparam int WIDTH = 8;
  localparam int SYNC  = 2;
  localparam int TO    = 8;
  localparam int CW    = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          clr_err = 1'b0;
  logic          done;
  logic          busy;
  logic          timeout_err;
  logic [CW-1:0] xfer_count;

  cdc_req_sender_if #(.WIDTH(WIDTH)) bus ();

  cdc_req_sender #(
    .WIDTH          (WIDTH),
    .SYNC_STAGES    (SYNC),
    .TIMEOUT_CYCLES (TO),
    .CNT_WIDTH      (CW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus.slave),
    .done        (done),
    .busy        (busy),
    .timeout_err (timeout_err),
    .clr_err     (clr_err),
    .xfer_count  (xfer_count)
  );

  initial forever #5 clk = ~clk;

  int               n_checks = 0;
  int               n_err = 0;
  logic [WIDTH-1:0] exp_q[$];
  logic [CW-1:0]    exp_cnt = '0;
  bit               auto_ack = 1'b1;
  bit               prev_done = 1'b0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Completed-transfer model: counts done pulses, cleared by reset.
  always @(negedge clk) begin
    if (rst) begin
      exp_cnt = '0;
    end else if (done) begin
      exp_cnt = exp_cnt + 1'b1;
      chk("xfer_count", 32'(xfer_count), 32'(exp_cnt));
      chk("done_single_cycle", 32'(prev_done), 0);
    end
    prev_done = done;
  end

  // Receive-side model: ack 3 cycles after req rises, drop it 3 cycles after req falls.
  initial begin
    logic [WIDTH-1:0] held;
    logic [WIDTH-1:0] w;
    int               k;
    bus.ack_async = 1'b0;
    forever begin
      wait (bus.req === 1'b1 && auto_ack && !rst);
      @(negedge clk);
      if (exp_q.size() > 0) begin
        w = exp_q.pop_front();
        chk("data_out", 32'(bus.data_out), 32'(w));
      end else begin
        chk("unexpected_req", exp_q.size(), 1);
      end
      held = bus.data_out;
      repeat (2) begin
        @(negedge clk);
        chk("data_hold_req", 32'(bus.data_out), 32'(held));
      end
      bus.ack_async = 1'b1;
      k = 0;
      while (bus.req === 1'b1 && k < 20) begin
        @(negedge clk);
        k++;
        if (bus.req === 1'b1) chk("data_hold_ack", 32'(bus.data_out), 32'(held));
      end
      chk("req_fall_latency", k, SYNC + 1);
      repeat (3) begin
        @(negedge clk);
        if (!rst) chk("data_hold_release", 32'(bus.data_out), 32'(held));
      end
      bus.ack_async = 1'b0;
    end
  end

  task automatic wait_ready();
    int t = 0;
    while (bus.send_ready !== 1'b1 && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (bus.send_ready !== 1'b1) chk("ready_wait", 32'(bus.send_ready), 1);
  endtask

  task automatic wait_done(input int budget);
    int t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (done !== 1'b1 && t < budget);
    if (done !== 1'b1) chk("done_wait", 32'(done), 1);
  endtask

  task automatic send_one(input logic [WIDTH-1:0] w);
    wait_ready();
    bus.send_valid = 1'b1;
    bus.send_data  = w;
    exp_q.push_back(w);
    @(negedge clk);
    bus.send_valid = 1'b0;
    bus.send_data  = 8'hFF;
    chk("req_rise", 32'(bus.req), 1);
    chk("ready_low", 32'(bus.send_ready), 0);
  endtask

  initial begin
    int           t;
    logic [CW-1:0] wrap_seq [5];
    wrap_seq = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    bus.send_valid = 1'b0;
    bus.send_data  = '0;

    #50;
    chk("rst_req", 32'(bus.req), 0);
    chk("rst_data", 32'(bus.data_out), 0);
    chk("rst_ready", 32'(bus.send_ready), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_count", 32'(xfer_count), 0);
    chk("rst_err", 32'(timeout_err), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    send_one(8'hA5);
    wait_done(60);
    chk("data_after_done", 32'(bus.data_out), 32'h A5);

    // Backpressure: valid stays high, second word taken in the done cycle.
    wait_ready();
    bus.send_valid = 1'b1;
    bus.send_data  = 8'h11;
    exp_q.push_back(8'h11);
    @(negedge clk);
    chk("bp_req", 32'(bus.req), 1);
    chk("bp_data", 32'(bus.data_out), 32'h11);
    chk("bp_ready_low", 32'(bus.send_ready), 0);
    bus.send_data = 8'h22;
    exp_q.push_back(8'h22);
    wait_done(60);
    chk("bp_ready_with_done", 32'(bus.send_ready), 1);
    @(negedge clk);
    bus.send_valid = 1'b0;
    chk("bp_capture", 32'(bus.data_out), 32'h22);
    chk("bp_req2", 32'(bus.req), 1);
    wait_done(60);

    // Timeout: receiver silent for a while.
    auto_ack = 1'b0;
    send_one(8'h3C);
    repeat (TO - 1) @(negedge clk);
    chk("timeout_early", 32'(timeout_err), 0);
    @(negedge clk);
    chk("timeout_set", 32'(timeout_err), 1);
    chk("timeout_req_held", 32'(bus.req), 1);
    repeat (5) @(negedge clk);
    chk("timeout_still_waiting", 32'(busy), 1);
    auto_ack = 1'b1;
    wait_done(60);
    chk("err_sticky", 32'(timeout_err), 1);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    chk("err_cleared", 32'(timeout_err), 0);

    // Reset while in RELEASE.
    send_one(8'h5A);
    t = 0;
    while (!(busy === 1'b1 && bus.req === 1'b0) && t < 40) begin
      @(negedge clk);
      t++;
    end
    chk("reached_release", 32'(busy && !bus.req), 1);
    #1 rst = 1'b1;
    #1;
    chk("midrst_req", 32'(bus.req), 0);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_count", 32'(xfer_count), 0);
    chk("midrst_data", 32'(bus.data_out), 0);
    repeat (6) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      send_one(8'h40 + 8'(i));
      wait_done(60);
      chk("wrap_seq", 32'(xfer_count), 32'(wrap_seq[i]));
    end

    repeat (4) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    chk("final_err_clear", 32'(timeout_err), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
